forward_south_buffered: RTL and testbench

- Registered southbound forwarding stage of the mesh router; the opposite direction of the northbound forwarding stage.
- Accepts 16-bit packets through a valid/ready input and buffers them in a small in-order FIFO.
- Packets with dy<0 are forwarded south with dy incremented toward 0. Packets with dy==0 are ejected to the local port. Packets with dy>0 are illegal; they are dropped and counted.
- Packet format: [15:12] dx (signed), [11:8] dy (signed, two's complement), [7:0] payload.

---
 rtl/forward_south_buffered_if.sv | 10 +
 rtl/forward_south_buffered.sv | 157 +++++++++++++++
 tb/tb_forward_south_buffered.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_south_buffered_if.sv
// Packet channel: 16-bit packet with valid/ready handshake.
// The master drives packet/valid; the slave drives ready.
interface forward_south_buffered_if;
  logic [15:0] packet;
  logic        valid;
  logic        ready;

  modport master (output packet, output valid, input ready);
  modport slave  (input packet, input valid, output ready);
endinterface

// File: rtl/forward_south_buffered.sv
// Southbound forwarding stage: an in-order input FIFO feeding a registered
// south output (dy stepped toward 0) and a registered local output (dy==0).
// Packets with dy>0 are dropped, pulsed on err_pulse and counted.
module forward_south_buffered #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  forward_south_buffered_if.slave  in_if,
  forward_south_buffered_if.master south_if,
  forward_south_buffered_if.master local_if,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err_pulse,
  output logic [ERR_W-1:0]        err_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    HEAD_SOUTH,
    HEAD_LOCAL,
    HEAD_ILLEGAL
  } head_e;

  logic [15:0]    mem_q [DEPTH];
  logic [15:0]    mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    south_pkt_q, south_pkt_d;
  logic           south_vld_q, south_vld_d;
  logic [15:0]    local_pkt_q, local_pkt_d;
  logic           local_vld_q, local_vld_d;
  logic           err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [15:0]    head;
  logic [4:0]     dy_inc;
  head_e          head_cls;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_if.valid && !full;

  assign in_if.ready     = !full;
  assign south_if.packet = south_pkt_q;
  assign south_if.valid  = south_vld_q;
  assign local_if.packet = local_pkt_q;
  assign local_if.valid  = local_vld_q;
  assign fifo_count      = count_q;
  assign err_pulse       = err_pulse_q;
  assign err_count       = err_cnt_q;

  // Classify the FIFO head by the sign of dy and precompute dy+1.
  always_comb begin
    head   = mem_q[rd_ptr_q];
    dy_inc = {head[11], head[11:8]} + 5'd1;
    if (head[11]) begin
      head_cls = HEAD_SOUTH;
    end else if (head[11:8] == 4'd0) begin
      head_cls = HEAD_LOCAL;
    end else begin
      head_cls = HEAD_ILLEGAL;
    end
  end

  // Pop only when the head's own target can take it; a blocked head stalls all.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      unique case (head_cls)
        HEAD_SOUTH: pop = !south_vld_q || south_if.ready;
        HEAD_LOCAL: pop = !local_vld_q || local_if.ready;
        default:    pop = 1'b1;
      endcase
    end
  end

  // Next-state for FIFO, output registers and error tracking.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    south_pkt_d = south_pkt_q;
    south_vld_d = south_vld_q;
    local_pkt_d = local_pkt_q;
    local_vld_d = local_vld_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_if.packet;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Accepted output clears; a same-cycle load below overrides the clear.
    if (south_vld_q && south_if.ready) south_vld_d = 1'b0;
    if (local_vld_q && local_if.ready) local_vld_d = 1'b0;

    if (pop) begin
      unique case (head_cls)
        HEAD_SOUTH: begin
          south_pkt_d = {head[15:12], dy_inc[3:0], head[7:0]};
          south_vld_d = 1'b1;
        end
        HEAD_LOCAL: begin
          local_pkt_d = head;
          local_vld_d = 1'b1;
        end
        default: begin
          err_pulse_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      endcase
    end
  end

  // State registers; FIFO storage needs no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      south_pkt_q <= '0;
      south_vld_q <= 1'b0;
      local_pkt_q <= '0;
      local_vld_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      south_pkt_q <= south_pkt_d;
      south_vld_q <= south_vld_d;
      local_pkt_q <= local_pkt_d;
      local_vld_q <= local_vld_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_forward_south_buffered.sv
// Bench for forward_south_buffered: directed scenarios plus a randomized run
// scored against per-output expected-packet queues.
module tb_forward_south_buffered;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned ERR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   err_pulse;
  logic [ERR_W-1:0]       err_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  forward_south_buffered_if in_if ();
  forward_south_buffered_if south_if ();
  forward_south_buffered_if local_if ();

  forward_south_buffered #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if),
    .south_if   (south_if),
    .local_if   (local_if),
    .fifo_count (fifo_count),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_if.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // dy+1 in plain signed arithmetic, keeping the low 4 bits.
  function automatic logic [15:0] south_xform(input logic [15:0] p);
    int          dy;
    logic [31:0] nd;
    dy = int'(signed'(p[11:8]));
    nd = 32'(dy + 1);
    return {p[15:12], nd[3:0], p[7:0]};
  endfunction

  // Push a list of packets, one per cycle whenever in_ready allows.
  task automatic push_list(input logic [15:0] pk [$], output int pushed);
    int guard;
    pushed = 0;
    guard  = 0;
    while (pushed < pk.size() && guard < 40) begin
      if (in_if.ready) begin
        in_if.valid  = 1'b1;
        in_if.packet = pk[pushed];
        pushed++;
      end else begin
        in_if.valid = 1'b0;
      end
      tick();
      guard++;
    end
    in_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
    n_cmp++; if (south_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_south_valid got=%0b exp=0", south_if.valid); end
    n_cmp++; if (local_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_local_valid got=%0b exp=0", local_if.valid); end
    n_cmp++; if (south_if.packet !== 16'h0000) begin n_fail++; $display("FAIL reset_south_packet got=%h exp=0000", south_if.packet); end
    n_cmp++; if (local_if.packet !== 16'h0000) begin n_fail++; $display("FAIL reset_local_packet got=%h exp=0000", local_if.packet); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); end
    n_cmp++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    n_cmp++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_if.ready); end
  endtask

  task automatic test_south_basic();
    south_if.ready = 1'b1;
    local_if.ready = 1'b0;
    in_if.packet = 16'h3E55;
    in_if.valid  = 1'b1;
    tick();
    in_if.valid = 1'b0;
    n_cmp++; if (south_if.valid !== 1'b0) begin n_fail++; $display("FAIL south_latency_early got=%0b exp=0", south_if.valid); end
    tick();
    n_cmp++; if (south_if.valid !== 1'b1) begin n_fail++; $display("FAIL south_basic_valid got=%0b exp=1", south_if.valid); end
    n_cmp++; if (south_if.packet !== 16'h3F55) begin n_fail++; $display("FAIL south_basic_packet got=%h exp=3f55", south_if.packet); end
    n_cmp++; if (local_if.valid !== 1'b0) begin n_fail++; $display("FAIL south_basic_local_valid got=%0b exp=0", local_if.valid); end
    n_cmp++; if (err_count !== '0) begin n_fail++; $display("FAIL south_basic_err_count got=%0d exp=0", err_count); end
    tick();
    n_cmp++; if (south_if.valid !== 1'b0) begin n_fail++; $display("FAIL south_basic_clear got=%0b exp=0", south_if.valid); end
  endtask

  task automatic test_local_hold();
    local_if.ready = 1'b0;
    in_if.packet = 16'h1042;
    in_if.valid  = 1'b1;
    tick();
    in_if.valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (local_if.valid !== 1'b1) begin n_fail++; $display("FAIL local_hold_valid[%0d] got=%0b exp=1", i, local_if.valid); end
      n_cmp++; if (local_if.packet !== 16'h1042) begin n_fail++; $display("FAIL local_hold_packet[%0d] got=%h exp=1042", i, local_if.packet); end
      if (i < 4) tick();
    end
    local_if.ready = 1'b1;
    tick();
    n_cmp++; if (local_if.valid !== 1'b0) begin n_fail++; $display("FAIL local_clear got=%0b exp=0", local_if.valid); end
    local_if.ready = 1'b0;
  endtask

  task automatic test_illegal();
    south_if.ready = 1'b1;
    local_if.ready = 1'b1;
    in_if.packet = 16'h0300;
    in_if.valid  = 1'b1;
    tick();
    in_if.valid = 1'b0;
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_early got=%0b exp=0", err_pulse); end
    tick();
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse got=%0b exp=1", err_pulse); end
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL illegal_count got=%0d exp=1", err_count); end
    n_cmp++; if (south_if.valid !== 1'b0 || local_if.valid !== 1'b0) begin n_fail++; $display("FAIL illegal_no_output got=%0b%0b exp=00", south_if.valid, local_if.valid); end
    tick();
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_width got=%0b exp=0", err_pulse); end
    in_if.packet = 16'h0300;
    in_if.valid  = 1'b1;
    repeat (299) tick();
    in_if.valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL illegal_saturate got=%0d exp=255", err_count); end
    n_cmp++; if (fifo_count !== '0) begin n_fail++; $display("FAIL illegal_fifo_empty got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] pk [$];
    int pushed;
    south_if.ready = 1'b0;
    local_if.ready = 1'b0;
    pk = '{16'h1E01, 16'h0002, 16'h2E03, 16'h3E04};
    push_list(pk, pushed);
    tick();
    n_cmp++; if (pushed !== 4) begin n_fail++; $display("FAIL rmid_pushed got=%0d exp=4", pushed); end
    n_cmp++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL rmid_pre_count got=%0d exp=2", fifo_count); end
    n_cmp++; if (south_if.valid !== 1'b1 || local_if.valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valids got=%0b%0b exp=11", south_if.valid, local_if.valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (south_if.valid !== 1'b0 || local_if.valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valids got=%0b%0b exp=00", south_if.valid, local_if.valid); end
    n_cmp++; if (fifo_count !== '0) begin n_fail++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
    n_cmp++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got=%0b exp=1", in_if.ready); end
    n_cmp++; if (err_count !== '0) begin n_fail++; $display("FAIL rmid_err_count got=%0d exp=0", err_count); end
    tick();
    n_cmp++; if (south_if.valid !== 1'b0 || local_if.valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_survivor got=%0b%0b exp=00", south_if.valid, local_if.valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] pk [$];
    logic [15:0] ex [$];
    int pushed;
    int got;
    int guard;
    south_if.ready = 1'b0;
    local_if.ready = 1'b1;
    pk = '{16'h1E11, 16'h2F22, 16'h3833};
    ex = '{16'h1F11, 16'h2022, 16'h3933};
    push_list(pk, pushed);
    n_cmp++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL bp_count got=%0d exp=2", fifo_count); end
    n_cmp++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%0b exp=0", in_if.ready); end
    n_cmp++; if (south_if.packet !== 16'h1F11) begin n_fail++; $display("FAIL bp_head_packet got=%h exp=1f11", south_if.packet); end
    got = 0;
    guard = 0;
    while (got < 3 && guard < 30) begin
      south_if.ready = guard[0];
      if (south_if.valid && south_if.ready) begin
        n_cmp++; if (south_if.packet !== ex[got]) begin n_fail++; $display("FAIL bp_order[%0d] got=%h exp=%h", got, south_if.packet, ex[got]); end
        got++;
      end
      tick();
      guard++;
    end
    south_if.ready = 1'b0;
    n_cmp++; if (got !== 3) begin n_fail++; $display("FAIL bp_drained got=%0d exp=3", got); end
    n_cmp++; if (fifo_count !== '0) begin n_fail++; $display("FAIL bp_final_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] p [8];
    south_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p[i] = {4'($urandom), 1'b1, 3'($urandom), 8'($urandom)};
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        n_cmp++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, in_if.ready); end
        in_if.valid  = 1'b1;
        in_if.packet = p[i];
      end else begin
        in_if.valid = 1'b0;
      end
      if (i >= 2) begin
        n_cmp++; if (south_if.valid !== 1'b1 || south_if.packet !== south_xform(p[i-2])) begin n_fail++; $display("FAIL b2b_out[%0d] got=%0b/%h exp=1/%h", i - 2, south_if.valid, south_if.packet, south_xform(p[i-2])); end
      end
      tick();
    end
    in_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_hol();
    logic [15:0] pk [$];
    logic [15:0] ex_s [$];
    int pushed;
    int guard;
    int s_got;
    int l_got;
    apply_reset();
    south_if.ready = 1'b0;
    local_if.ready = 1'b1;
    pk = '{16'h0E0A, 16'h0F01, 16'h0002};
    ex_s = '{16'h0F0A, 16'h0001};
    push_list(pk, pushed);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (local_if.valid !== 1'b0) begin n_fail++; $display("FAIL hol_local_blocked[%0d] got=%0b exp=0", i, local_if.valid); end
      n_cmp++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL hol_count[%0d] got=%0d exp=2", i, fifo_count); end
      tick();
    end
    south_if.ready = 1'b1;
    s_got = 0;
    l_got = 0;
    guard = 0;
    while ((s_got < 2 || l_got < 1) && guard < 20) begin
      if (south_if.valid && south_if.ready) begin
        n_cmp++; if (s_got >= 2 || south_if.packet !== ex_s[s_got]) begin n_fail++; $display("FAIL hol_south[%0d] got=%h", s_got, south_if.packet); end
        s_got++;
      end
      if (local_if.valid && local_if.ready) begin
        n_cmp++; if (local_if.packet !== 16'h0002 || s_got < 1) begin n_fail++; $display("FAIL hol_local got=%h exp=0002 south_seen=%0d", local_if.packet, s_got); end
        l_got++;
      end
      tick();
      guard++;
    end
    n_cmp++; if (s_got !== 2 || l_got !== 1) begin n_fail++; $display("FAIL hol_drain got=%0d/%0d exp=2/1", s_got, l_got); end
  endtask

  task automatic test_random();
    logic [15:0] exp_s [$];
    logic [15:0] exp_l [$];
    logic [15:0] exp;
    logic signed [3:0] dy;
    int illegal;
    int pulses;
    int exp_cnt;
    logic prev_s_hold;
    logic prev_l_hold;
    logic [15:0] prev_s_pkt;
    logic [15:0] prev_l_pkt;
    apply_reset();
    illegal = 0;
    pulses = 0;
    prev_s_hold = 1'b0;
    prev_l_hold = 1'b0;
    prev_s_pkt = '0;
    prev_l_pkt = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (err_pulse === 1'b1) pulses++;
      if (prev_s_hold) begin
        n_cmp++; if (south_if.valid !== 1'b1 || south_if.packet !== prev_s_pkt) begin n_fail++; $display("FAIL rnd_south_hold cyc=%0d got=%0b/%h exp=1/%h", cyc, south_if.valid, south_if.packet, prev_s_pkt); end
      end
      if (prev_l_hold) begin
        n_cmp++; if (local_if.valid !== 1'b1 || local_if.packet !== prev_l_pkt) begin n_fail++; $display("FAIL rnd_local_hold cyc=%0d got=%0b/%h exp=1/%h", cyc, local_if.valid, local_if.packet, prev_l_pkt); end
      end
      if (cyc < 500) begin
        in_if.valid    = ($urandom_range(0, 99) < 70);
        in_if.packet   = 16'($urandom);
        south_if.ready = ($urandom_range(0, 99) < 60);
        local_if.ready = ($urandom_range(0, 99) < 60);
      end else begin
        in_if.valid    = 1'b0;
        south_if.ready = 1'b1;
        local_if.ready = 1'b1;
      end
      if (in_if.valid && in_if.ready) begin
        dy = in_if.packet[11:8];
        if (dy < 0) exp_s.push_back(south_xform(in_if.packet));
        else if (dy == 0) exp_l.push_back(in_if.packet);
        else illegal++;
      end
      if (south_if.valid && south_if.ready) begin
        exp = (exp_s.size() > 0) ? exp_s.pop_front() : 16'hxxxx;
        n_cmp++; if (south_if.packet !== exp) begin n_fail++; $display("FAIL rnd_south cyc=%0d got=%h exp=%h", cyc, south_if.packet, exp); end
      end
      if (local_if.valid && local_if.ready) begin
        exp = (exp_l.size() > 0) ? exp_l.pop_front() : 16'hxxxx;
        n_cmp++; if (local_if.packet !== exp) begin n_fail++; $display("FAIL rnd_local cyc=%0d got=%h exp=%h", cyc, local_if.packet, exp); end
      end
      prev_s_hold = south_if.valid && !south_if.ready;
      prev_l_hold = local_if.valid && !local_if.ready;
      prev_s_pkt  = south_if.packet;
      prev_l_pkt  = local_if.packet;
      tick();
    end
    exp_cnt = (illegal > 255) ? 255 : illegal;
    n_cmp++; if (exp_s.size() != 0 || exp_l.size() != 0) begin n_fail++; $display("FAIL rnd_leftover got=%0d/%0d exp=0/0", exp_s.size(), exp_l.size()); end
    n_cmp++; if (err_count !== ERR_W'(exp_cnt)) begin n_fail++; $display("FAIL rnd_err_count got=%0d exp=%0d", err_count, exp_cnt); end
    n_cmp++; if (pulses !== illegal) begin n_fail++; $display("FAIL rnd_err_pulses got=%0d exp=%0d", pulses, illegal); end
    n_cmp++; if (fifo_count !== '0) begin n_fail++; $display("FAIL rnd_fifo_count got=%0d exp=0", fifo_count); end
  endtask

  initial begin
    in_if.valid    = 1'b0;
    in_if.packet   = '0;
    south_if.ready = 1'b0;
    local_if.ready = 1'b0;
    test_reset();
    test_south_basic();
    test_local_hold();
    test_illegal();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    test_hol();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
